// File: rtl/traffic_ctrl_act_pkg.sv
// traffic_pkg: shared constants for the actuated traffic-light controller.
//   - state codes (also driven out on the debug 'phase' port)
//   - light patterns, bit order {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g}
//   - bit positions of each lamp inside that vector
package traffic_pkg;

    localparam logic [2:0] ST_NS_GREEN  = 3'd0;
    localparam logic [2:0] ST_NS_YELLOW = 3'd1;
    localparam logic [2:0] ST_ALL_RED_A = 3'd2;
    localparam logic [2:0] ST_EW_GREEN  = 3'd3;
    localparam logic [2:0] ST_EW_YELLOW = 3'd4;
    localparam logic [2:0] ST_ALL_RED_B = 3'd5;
    localparam logic [2:0] ST_FLASH     = 3'd6;

    localparam logic [5:0] LT_NS_GREEN  = 6'b001100;
    localparam logic [5:0] LT_NS_YELLOW = 6'b010100;
    localparam logic [5:0] LT_ALL_RED   = 6'b100100;
    localparam logic [5:0] LT_EW_GREEN  = 6'b100001;
    localparam logic [5:0] LT_EW_YELLOW = 6'b100010;
    localparam logic [5:0] LT_DARK      = 6'b000000;

    localparam int unsigned NS_R = 5;
    localparam int unsigned NS_Y = 4;
    localparam int unsigned NS_G = 3;
    localparam int unsigned EW_R = 2;
    localparam int unsigned EW_Y = 1;
    localparam int unsigned EW_G = 0;

endpackage

// File: rtl/traffic_ctrl_act_if.sv
// traffic_ctrl_act_if: controller-side bundle.
//   master: drives tick / ew_sense / ped_req / flash_mode, watches the lamps
//   slave : the controller; receives the inputs, drives lights / walk / phase
interface traffic_ctrl_act_if;
    logic       tick;
    logic       ew_sense;
    logic       ped_req;
    logic       flash_mode;
    logic [5:0] lights;
    logic       walk;
    logic [2:0] phase;

    modport master (output tick, ew_sense, ped_req, flash_mode,
                    input  lights, walk, phase);
    modport slave  (input  tick, ew_sense, ped_req, flash_mode,
                    output lights, walk, phase);
endinterface

// File: rtl/traffic_ctrl_act_phase_timer.sv
// phase_timer: CW-bit tick counter.
//   clk, clr_n : clock, synchronous active-low reset
//   clear      : force count to 0 (overrides tick)
//   tick       : advance by one when set
//   sat        : count never goes beyond this value
//   cnt        : current count
module phase_timer #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          clear,
    input  logic          tick,
    input  logic [CW-1:0] sat,
    output logic [CW-1:0] cnt
);
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (tick && (cnt_q < sat))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!clr_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/traffic_ctrl_act.sv
// traffic_ctrl_act: actuated NS/EW traffic-light controller with pedestrian
// WALK and night flashing.
//   clk, clr_n : clock, synchronous active-low reset
//   bus.slave  : tick, ew_sense, ped_req, flash_mode in;
//                lights {ns_r,ns_y,ns_g,ew_r,ew_y,ew_g}, walk, phase out
// Outputs are Moore-decoded from registered state.
module traffic_ctrl_act
    import traffic_pkg::*;
#(
    parameter int CW         = 8,
    parameter int T_GREEN    = 16,
    parameter int T_EW_GREEN = 8,
    parameter int T_YELLOW   = 4,
    parameter int T_ALLRED   = 2,
    parameter int T_FLASH    = 8
) (
    input logic               clk,
    input logic               clr_n,
    traffic_ctrl_act_if.slave bus
);
    localparam int T_MAX = (1 << CW) - 1;

    if (CW < 1 || CW > 30 ||
        T_GREEN    < 1 || T_GREEN    > T_MAX ||
        T_EW_GREEN < 1 || T_EW_GREEN > T_MAX ||
        T_YELLOW   < 1 || T_YELLOW   > T_MAX ||
        T_ALLRED   < 1 || T_ALLRED   > T_MAX ||
        T_FLASH    < 1 || T_FLASH    > T_MAX) begin : g_bad_param
        $error("traffic_ctrl_act: phase durations must be in 1..2^CW-1");
    end

    localparam logic [CW-1:0] GREEN_LAST  = CW'(T_GREEN - 1);
    localparam logic [CW-1:0] EWG_LAST    = CW'(T_EW_GREEN - 1);
    localparam logic [CW-1:0] YELLOW_LAST = CW'(T_YELLOW - 1);
    localparam logic [CW-1:0] ALLRED_LAST = CW'(T_ALLRED - 1);
    localparam logic [CW-1:0] FLASH_LAST  = CW'(T_FLASH - 1);

    logic [2:0]    state_q, state_d;
    logic          ew_pend_q, ew_pend_d;
    logic          walk_pend_q, walk_pend_d;
    logic          walk_act_q, walk_act_d;
    logic          blink_q, blink_d;
    logic [CW-1:0] cnt, bcnt, cnt_sat;
    logic          enter_ew, blink_wrap;
    logic [5:0]    lights_o;
    logic          walk_o;

    // Phase counter: clears on any state change. Saturating at the state's
    // last count is what makes NS_GREEN park at T_GREEN-1 while waiting.
    always_comb begin
        cnt_sat = '1;
        case (state_q)
            ST_NS_GREEN:                 cnt_sat = GREEN_LAST;
            ST_NS_YELLOW, ST_EW_YELLOW:  cnt_sat = YELLOW_LAST;
            ST_ALL_RED_A, ST_ALL_RED_B:  cnt_sat = ALLRED_LAST;
            ST_EW_GREEN:                 cnt_sat = EWG_LAST;
            default:                     cnt_sat = '1;
        endcase
    end

    phase_timer #(.CW(CW)) u_phase_tmr (
        .clk   (clk),
        .clr_n (clr_n),
        .clear (state_d != state_q),
        .tick  (bus.tick),
        .sat   (cnt_sat),
        .cnt   (cnt)
    );

    // Blink timer idles at 0 outside FLASH so the first half-period after
    // entry is a full T_FLASH ticks.
    assign blink_wrap = bus.tick && (bcnt == FLASH_LAST);

    phase_timer #(.CW(CW)) u_blink_tmr (
        .clk   (clk),
        .clr_n (clr_n),
        .clear ((state_q != ST_FLASH) || blink_wrap),
        .tick  (bus.tick),
        .sat   (FLASH_LAST),
        .cnt   (bcnt)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!clr_n) state_q <= ST_ALL_RED_B;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_NS_GREEN:
                if (bus.tick && cnt == GREEN_LAST && ew_pend_q) state_d = ST_NS_YELLOW;
            ST_NS_YELLOW:
                if (bus.tick && cnt == YELLOW_LAST) state_d = ST_ALL_RED_A;
            ST_ALL_RED_A:
                if (bus.tick && cnt == ALLRED_LAST)
                    state_d = bus.flash_mode ? ST_FLASH : ST_EW_GREEN;
            ST_EW_GREEN:
                if (bus.tick && cnt == EWG_LAST) state_d = ST_EW_YELLOW;
            ST_EW_YELLOW:
                if (bus.tick && cnt == YELLOW_LAST) state_d = ST_ALL_RED_B;
            ST_ALL_RED_B:
                if (bus.tick && cnt == ALLRED_LAST)
                    state_d = bus.flash_mode ? ST_FLASH : ST_NS_GREEN;
            ST_FLASH:
                if (bus.tick && !bus.flash_mode) state_d = ST_ALL_RED_B;
            default:
                state_d = ST_ALL_RED_B;
        endcase
    end

    // Request latches. A request seen on the EW_GREEN entry edge survives
    // the clear (set wins) and is served in the following EW phase.
    assign enter_ew = (state_d == ST_EW_GREEN) && (state_q != ST_EW_GREEN);

    always_comb begin
        ew_pend_d   = ew_pend_q;
        walk_pend_d = walk_pend_q;
        walk_act_d  = walk_act_q;
        if (enter_ew) begin
            ew_pend_d   = 1'b0;
            walk_pend_d = 1'b0;
            walk_act_d  = walk_pend_q;
        end
        if (bus.ew_sense || bus.ped_req) ew_pend_d   = 1'b1;
        if (bus.ped_req)                 walk_pend_d = 1'b1;
    end

    always_comb begin
        blink_d = 1'b0;
        if (state_d == ST_FLASH) begin
            if (state_q != ST_FLASH) blink_d = 1'b1;
            else if (blink_wrap)     blink_d = ~blink_q;
            else                     blink_d = blink_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            ew_pend_q   <= 1'b0;
            walk_pend_q <= 1'b0;
            walk_act_q  <= 1'b0;
            blink_q     <= 1'b0;
        end else begin
            ew_pend_q   <= ew_pend_d;
            walk_pend_q <= walk_pend_d;
            walk_act_q  <= walk_act_d;
            blink_q     <= blink_d;
        end
    end

    // Output decode; unused codes show all-red
    always_comb begin
        lights_o = LT_ALL_RED;
        walk_o   = 1'b0;
        case (state_q)
            ST_NS_GREEN:  lights_o = LT_NS_GREEN;
            ST_NS_YELLOW: lights_o = LT_NS_YELLOW;
            ST_EW_GREEN: begin
                lights_o = LT_EW_GREEN;
                walk_o   = walk_act_q;
            end
            ST_EW_YELLOW: lights_o = LT_EW_YELLOW;
            ST_FLASH: begin
                lights_o       = LT_DARK;
                lights_o[NS_Y] = blink_q;
                lights_o[EW_R] = blink_q;
            end
            default:      lights_o = LT_ALL_RED;
        endcase
    end

    assign bus.lights = lights_o;
    assign bus.walk   = walk_o;
    assign bus.phase  = state_q;
endmodule

// File: tb/tb_traffic_ctrl_act.sv
module tb_traffic_ctrl_act;
    import traffic_pkg::*;

    localparam logic [5:0] L_NSG = 6'b001100;
    localparam logic [5:0] L_NSY = 6'b010100;
    localparam logic [5:0] L_RED = 6'b100100;
    localparam logic [5:0] L_EWG = 6'b100001;
    localparam logic [5:0] L_EWY = 6'b100010;
    localparam logic [5:0] L_FON = 6'b010100;
    localparam logic [5:0] L_OFF = 6'b000000;

    typedef struct {
        logic       clr_n, tick, ew, ped, flash;
        logic [5:0] lt;
        logic       wk;
        logic [2:0] ph;
    } vec_t;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    vec_t vecs[8];

    traffic_ctrl_act_if bus();

    traffic_ctrl_act dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [5:0] el, input logic ew, input logic [2:0] ep);
        total++;
        if (bus.lights !== el || bus.walk !== ew || bus.phase !== ep) begin
            bad++;
            $display("FAIL %s @%0t: got lights=%b walk=%b phase=%0d, want lights=%b walk=%b phase=%0d",
                     name, $time, bus.lights, bus.walk, bus.phase, el, ew, ep);
        end
    endtask

    // n ticks of one state, tick on the first of every 'per' clocks
    task automatic run_ticks(input string name, input logic [5:0] el, input logic ew,
                             input logic [2:0] ep, input int n, input int per);
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < per; j++) begin
                bus.tick = (j == 0);
                step();
                chk(name, el, ew, ep);
            end
        end
    endtask

    task automatic do_reset(input string name);
        clr_n = 1'b0;
        bus.tick = 1'b1;
        step();
        chk(name, L_RED, 1'b0, ST_ALL_RED_B);
        clr_n = 1'b1;
    endtask

    initial begin
        bus.tick = 1'b0; bus.ew_sense = 1'b0; bus.ped_req = 1'b0; bus.flash_mode = 1'b0;

        // reset state, tick gating, requests ignored under reset, flash ignored in NS_GREEN
        vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, L_RED, 1'b0, ST_ALL_RED_B};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, L_RED, 1'b0, ST_ALL_RED_B};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, L_RED, 1'b0, ST_ALL_RED_B};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, L_RED, 1'b0, ST_ALL_RED_B};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, L_RED, 1'b0, ST_ALL_RED_B};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, L_NSG, 1'b0, ST_NS_GREEN};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, L_NSG, 1'b0, ST_NS_GREEN};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, L_NSG, 1'b0, ST_NS_GREEN};
        for (int v = 0; v < 8; v++) begin
            clr_n = vecs[v].clr_n; bus.tick = vecs[v].tick; bus.ew_sense = vecs[v].ew;
            bus.ped_req = vecs[v].ped; bus.flash_mode = vecs[v].flash;
            step();
            chk($sformatf("vec%0d", v), vecs[v].lt, vecs[v].wk, vecs[v].ph);
        end
        bus.ew_sense = 1'b0; bus.ped_req = 1'b0; bus.flash_mode = 1'b0;
        run_ticks("idle_hold", L_NSG, 1'b0, ST_NS_GREEN, 100, 1);

        // full cycle with defaults, ew_sense pulse at NS_GREEN tick 5
        do_reset("rst2");
        run_ticks("c2_arb0", L_RED, 1'b0, ST_ALL_RED_B, 1, 1);
        run_ticks("c2_nsg", L_NSG, 1'b0, ST_NS_GREEN, 5, 1);
        bus.ew_sense = 1'b1;
        run_ticks("c2_nsg", L_NSG, 1'b0, ST_NS_GREEN, 1, 1);
        bus.ew_sense = 1'b0;
        run_ticks("c2_nsg", L_NSG, 1'b0, ST_NS_GREEN, 10, 1);
        run_ticks("c2_nsy", L_NSY, 1'b0, ST_NS_YELLOW, 4, 1);
        run_ticks("c2_ara", L_RED, 1'b0, ST_ALL_RED_A, 2, 1);
        run_ticks("c2_ewg", L_EWG, 1'b0, ST_EW_GREEN, 8, 1);
        run_ticks("c2_ewy", L_EWY, 1'b0, ST_EW_YELLOW, 4, 1);
        run_ticks("c2_arb", L_RED, 1'b0, ST_ALL_RED_B, 2, 1);
        run_ticks("c2_nsg2", L_NSG, 1'b0, ST_NS_GREEN, 20, 1);

        // single-clock ped_req on a non-tick clock, tick every 4th clock
        bus.tick = 1'b0; bus.ped_req = 1'b1;
        step();
        chk("c3_req", L_NSG, 1'b0, ST_NS_GREEN);
        bus.ped_req = 1'b0;
        run_ticks("c3_nsy", L_NSY, 1'b0, ST_NS_YELLOW, 4, 4);
        run_ticks("c3_ara", L_RED, 1'b0, ST_ALL_RED_A, 2, 4);
        run_ticks("c3_walk", L_EWG, 1'b1, ST_EW_GREEN, 8, 4);
        run_ticks("c3_ewy", L_EWY, 1'b0, ST_EW_YELLOW, 4, 4);
        run_ticks("c3_arb", L_RED, 1'b0, ST_ALL_RED_B, 2, 4);
        run_ticks("c3_nsg", L_NSG, 1'b0, ST_NS_GREEN, 20, 4);

        // flash_mode raised during NS_YELLOW
        bus.ew_sense = 1'b1;
        run_ticks("c4_nsg", L_NSG, 1'b0, ST_NS_GREEN, 1, 1);
        bus.ew_sense = 1'b0;
        run_ticks("c4_nsy", L_NSY, 1'b0, ST_NS_YELLOW, 1, 1);
        bus.flash_mode = 1'b1;
        run_ticks("c4_nsy", L_NSY, 1'b0, ST_NS_YELLOW, 3, 1);
        run_ticks("c4_ara", L_RED, 1'b0, ST_ALL_RED_A, 2, 1);
        run_ticks("c4_fon", L_FON, 1'b0, ST_FLASH, 8, 1);
        run_ticks("c4_foff", L_OFF, 1'b0, ST_FLASH, 8, 1);
        run_ticks("c4_fon2", L_FON, 1'b0, ST_FLASH, 3, 1);
        bus.flash_mode = 1'b0;
        run_ticks("c4_arb", L_RED, 1'b0, ST_ALL_RED_B, 2, 1);

        // ew_pend survived FLASH; add a ped request, then reset mid EW_GREEN
        run_ticks("c5_nsg", L_NSG, 1'b0, ST_NS_GREEN, 2, 1);
        bus.ped_req = 1'b1;
        run_ticks("c5_nsg", L_NSG, 1'b0, ST_NS_GREEN, 1, 1);
        bus.ped_req = 1'b0;
        run_ticks("c5_nsg", L_NSG, 1'b0, ST_NS_GREEN, 13, 1);
        run_ticks("c5_nsy", L_NSY, 1'b0, ST_NS_YELLOW, 4, 1);
        run_ticks("c5_ara", L_RED, 1'b0, ST_ALL_RED_A, 2, 1);
        run_ticks("c5_walk", L_EWG, 1'b1, ST_EW_GREEN, 2, 1);
        bus.ped_req = 1'b1;
        run_ticks("c5_walk", L_EWG, 1'b1, ST_EW_GREEN, 1, 1);
        bus.ped_req = 1'b0;
        do_reset("c5_rst");
        run_ticks("c5_arb", L_RED, 1'b0, ST_ALL_RED_B, 1, 1);
        run_ticks("c5_pend_clr", L_NSG, 1'b0, ST_NS_GREEN, 30, 1);

        // ped_req exactly on the EW_GREEN entry edge
        bus.ew_sense = 1'b1;
        run_ticks("c6_nsg", L_NSG, 1'b0, ST_NS_GREEN, 1, 1);
        bus.ew_sense = 1'b0;
        run_ticks("c6_nsy", L_NSY, 1'b0, ST_NS_YELLOW, 4, 1);
        run_ticks("c6_ara", L_RED, 1'b0, ST_ALL_RED_A, 2, 1);
        bus.ped_req = 1'b1;
        run_ticks("c6_entry", L_EWG, 1'b0, ST_EW_GREEN, 1, 1);
        bus.ped_req = 1'b0;
        run_ticks("c6_ewg", L_EWG, 1'b0, ST_EW_GREEN, 7, 1);
        run_ticks("c6_ewy", L_EWY, 1'b0, ST_EW_YELLOW, 4, 1);
        run_ticks("c6_arb", L_RED, 1'b0, ST_ALL_RED_B, 2, 1);
        run_ticks("c6_nsg", L_NSG, 1'b0, ST_NS_GREEN, 16, 1);
        run_ticks("c6_nsy2", L_NSY, 1'b0, ST_NS_YELLOW, 4, 1);
        run_ticks("c6_ara2", L_RED, 1'b0, ST_ALL_RED_A, 2, 1);
        run_ticks("c6_walk2", L_EWG, 1'b1, ST_EW_GREEN, 8, 1);
        run_ticks("c6_ewy2", L_EWY, 1'b0, ST_EW_YELLOW, 4, 1);
        run_ticks("c6_arb2", L_RED, 1'b0, ST_ALL_RED_B, 2, 1);
        run_ticks("c6_nsg2", L_NSG, 1'b0, ST_NS_GREEN, 20, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
